// File: rtl/io_responder.sv
// Memory-mapped I/O responder for the single-cycle CPU data bus: LEDs, debounced DIP switches, timer.
// Define IO_TIMER_EN to build the TCNT/TCMP/STAT timer; without it those offsets read 0 and ignore writes.
module io_responder #(
  parameter int LED_W           = 24,
  parameter int SW_W            = 24,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Word offsets (byte offset >> 2) within the I/O page.
  typedef enum logic [5:0] {
    REG_LED   = 6'h18,
    REG_SW    = 6'h1C,
    REG_SWCHG = 6'h1D,
    REG_TCNT  = 6'h1E,
    REG_TCMP  = 6'h1F,
    REG_STAT  = 6'h20
  } reg_e;

  logic [5:0] word;
  logic       wr_led;
  logic       rd_swchg;
  logic       unused_bits;

  assign word        = addr[7:2];
  assign wr_led      = io_write && (word == REG_LED);
  assign rd_swchg    = io_read && (word == REG_SWCHG);
  assign unused_bits = ^{addr[1:0], wdata};

  // ---------------------------------------------------------------------------
  // LEDs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      led_out <= '0;
    end else if (wr_led) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      led_out <= wdata[LED_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Switches: 2-flop synchronizer, per-bit debounce counter, sticky change flags
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [SW_W-1:0]  sw_db;
  logic [SW_W-1:0]  sw_chg;
  logic [SW_W-1:0]  sw_hit;
  logic [CNT_W-1:0] db_cnt [SW_W];

  // sw_hit[i]: bit i has held its new level long enough and is accepted this edge.
  always_comb begin
    // NOTE: default first so no path leaves sw_hit unassigned, which would infer a latch.
    sw_hit = '0;
    for (int i = 0; i < SW_W; i++) begin
      sw_hit[i] = (sw_sync[i] != sw_db[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_db   <= '0;
      sw_chg  <= '0;
      // NOTE: the counters are plain flops, not a RAM, so they reset with everything else;
      // an in-flight debounce must restart from zero after reset.
      for (int i = 0; i < SW_W; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      for (int i = 0; i < SW_W; i++) begin
        if (sw_sync[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (sw_hit[i]) begin
          db_cnt[i] <= '0;
          sw_db[i]  <= sw_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
      // A new change on the same edge as the clear-on-read survives the clear.
      sw_chg <= (rd_swchg ? '0 : sw_chg) | sw_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
`ifdef IO_TIMER_EN
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [31:0] tcnt_inc;
  logic        match;
  logic        ten;
  logic        wr_tcnt;
  logic        wr_tcmp;
  logic        wr_stat;

  assign wr_tcnt  = io_write && (word == REG_TCNT);
  assign wr_tcmp  = io_write && (word == REG_TCMP);
  assign wr_stat  = io_write && (word == REG_STAT);
  assign tcnt_inc = tcnt + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt  <= '0;
      tcmp  <= '1;
      match <= 1'b0;
      ten   <= 1'b0;
    end else begin
      if (wr_tcnt) begin
        tcnt <= wdata;
      end else if (ten) begin
        tcnt <= tcnt_inc;
      end

      if (wr_tcmp) begin
        tcmp <= wdata;
      end

      if (wr_stat) begin
        ten <= wdata[1];
      end

      // A CPU write to TCNT suppresses the compare; a match beats a same-edge W1C.
      if (!wr_tcnt && ten && (tcnt_inc == tcmp)) begin
        match <= 1'b1;
      end else if (wr_stat && wdata[0]) begin
        match <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux: combinational from registered state, zero when no load is in progress
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (io_read) begin
      case (word)
        REG_LED:   rdata = 32'(led_out);
        REG_SW:    rdata = 32'(sw_db);
        REG_SWCHG: rdata = 32'(sw_chg);
`ifdef IO_TIMER_EN
        REG_TCNT:  rdata = tcnt;
        REG_TCMP:  rdata = tcmp;
        REG_STAT:  rdata = {30'd0, ten, match};
`endif
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: reads are scored against a queue of expected rdata values.
`timescale 1ns/1ps
module tb_io_responder;

  localparam int LED_W = 24;
  localparam int SW_W  = 24;
  localparam int DEB   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_read;
  logic             io_write;
  logic [7:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [SW_W-1:0]  sw_in;
  logic [LED_W-1:0] led_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clock = ~clock;

  io_responder #(
    .LED_W           (LED_W),
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_read  (io_read),
    .io_write (io_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  // Scoreboard: every load cycle pops one expectation, sampled mid-cycle.
  always @(negedge clock) begin
    logic [31:0] e;
    string       t;
    if (io_read === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read: rdata=0x%08h with no expectation queued", rdata);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rdata !== e) $display("FAIL %s: rdata=0x%08h expected 0x%08h", t, rdata, e);
        else             n_pass++;
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each bus task occupies one cycle; its access commits on the following rising edge.
  task automatic bus_idle();
    @(posedge clock); #1;
    io_read  = 1'b0;
    io_write = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    io_read  = 1'b0;
    io_write = 1'b1;
    addr     = a;
    wdata    = d;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] e, input string t);
    @(posedge clock); #1;
    io_write = 1'b0;
    io_read  = 1'b1;
    addr     = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic test_reset();
    reset = 1'b1; io_read = 1'b0; io_write = 1'b0;
    addr = 8'h00; wdata = 32'h0; sw_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    n_checks++;
    if (led_out !== 24'h0) $display("FAIL reset_led: led_out=0x%06h expected 0x000000", led_out);
    else                   n_pass++;
    addr = 8'h60;
    #1;
    n_checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata_idle: rdata=0x%08h expected 0x00000000", rdata);
    else                 n_pass++;
    bus_read(8'h60, 32'h0, "reset_led_reg");
    bus_read(8'h70, 32'h0, "reset_sw");
    bus_read(8'h74, 32'h0, "reset_swchg");
`ifdef IO_TIMER_EN
    bus_read(8'h78, 32'h0,        "reset_tcnt");
    bus_read(8'h7C, 32'hFFFFFFFF, "reset_tcmp");
    bus_read(8'h80, 32'h0,        "reset_stat");
`endif
    bus_idle();
  endtask

  task automatic test_led();
    bus_write(8'h60, 32'h00A5A5A5);
    bus_idle();
    n_checks++;
    if (led_out !== 24'hA5A5A5) $display("FAIL led_write: led_out=0x%06h expected 0xa5a5a5", led_out);
    else                        n_pass++;
    bus_read(8'h60, 32'h00A5A5A5, "led_readback");
    bus_idle();
    addr = 8'h60;
    #1;
    n_checks++;
    if (rdata !== 32'h0) $display("FAIL rdata_no_strobe: rdata=0x%08h expected 0x00000000", rdata);
    else                 n_pass++;
    bus_write(8'h60, 32'hFFFFFFFF);
    bus_read(8'h63, 32'h00FFFFFF, "led_trunc_low_addr_bits");
    // Illegal read+write together: write happens, rdata shows the pre-edge value.
    @(posedge clock); #1;
    io_read = 1'b1; io_write = 1'b1; addr = 8'h60; wdata = 32'h00123456;
    exp_q.push_back(32'h00FFFFFF);
    tag_q.push_back("rw_same_cycle");
    bus_idle();
    n_checks++;
    if (led_out !== 24'h123456) $display("FAIL rw_same_cycle_led: led_out=0x%06h expected 0x123456", led_out);
    else                        n_pass++;
  endtask

  task automatic test_unmapped();
    bus_write(8'h84, 32'hDEADBEEF);
    bus_write(8'h64, 32'hCAFEF00D);
    bus_read(8'h84, 32'h0, "unmapped_84");
    bus_read(8'h64, 32'h0, "unmapped_64");
    bus_read(8'h00, 32'h0, "unmapped_00");
    bus_read(8'h60, 32'h00123456, "led_after_unmapped");
    bus_idle();
  endtask

  task automatic test_sw_latency();
    bus_idle();
    sw_in = 24'h000001;
    for (int k = 1; k <= 20; k++) begin
      bus_read(8'h70, (k >= 2 + DEB) ? 32'h1 : 32'h0, $sformatf("sw_latency_k%0d", k));
    end
    bus_read(8'h74, 32'h1, "swchg_first_read");
    bus_read(8'h74, 32'h0, "swchg_second_read");
    bus_read(8'h70, 32'h1, "sw_after_swchg_reads");
    bus_idle();
  endtask

  task automatic test_sw_glitch();
    bus_idle();
    sw_in = 24'h000000;
    repeat (5) bus_idle();
    sw_in = 24'h000001;
    repeat (24) bus_idle();
    bus_read(8'h70, 32'h1, "glitch_sw");
    bus_read(8'h74, 32'h0, "glitch_swchg");
    bus_idle();
  endtask

  // SWCHG polled every cycle: the read on the accepting edge must not wipe the new flags.
  task automatic test_sw_pattern();
    bus_idle();
    sw_in = 24'h5A0F3C;
    for (int k = 1; k <= 19; k++) begin
      bus_read(8'h74, (k == 2 + DEB) ? 32'h005A0F3D : 32'h0, $sformatf("swchg_poll_k%0d", k));
    end
    bus_read(8'h70, 32'h005A0F3C, "sw_pattern");
    bus_idle();
  endtask

`ifdef IO_TIMER_EN
  task automatic test_timer_match();
    bus_write(8'h7C, 32'd10);
    bus_write(8'h78, 32'd0);
    bus_write(8'h80, 32'h2);
    for (int k = 0; k <= 8; k++) bus_read(8'h78, 32'(k), $sformatf("tcnt_k%0d", k));
    bus_read(8'h80, 32'h2, "stat_before_match");
    bus_read(8'h80, 32'h3, "stat_at_match");
    bus_read(8'h78, 32'd11, "tcnt_after_match");
    bus_write(8'h80, 32'h3);
    bus_read(8'h80, 32'h2, "stat_w1c");
    bus_read(8'h78, 32'd14, "tcnt_continues");
    bus_write(8'h7C, 32'd20);
    repeat (3) bus_idle();
    bus_write(8'h80, 32'h3);
    bus_read(8'h80, 32'h3, "stat_set_beats_w1c");
    bus_write(8'h80, 32'h3);
    bus_read(8'h80, 32'h2, "stat_cleared_again");
    bus_read(8'h7C, 32'd20, "tcmp_readback");
    bus_idle();
  endtask

  task automatic test_timer_wrap();
    bus_write(8'h78, 32'hFFFFFFFF);
    bus_read(8'h78, 32'hFFFFFFFF, "tcnt_loaded_max");
    bus_read(8'h78, 32'h0, "tcnt_wrapped");
    bus_read(8'h80, 32'h2, "stat_after_wrap");
    repeat (17) bus_idle();
    bus_write(8'h78, 32'h00001000);
    bus_read(8'h78, 32'h00001000, "tcnt_write_on_match");
    bus_read(8'h80, 32'h2, "stat_no_match_on_write");
    bus_read(8'h78, 32'h00001002, "tcnt_after_write");
    bus_idle();
  endtask
`else
  task automatic test_no_timer();
    bus_write(8'h78, 32'd5);
    bus_read(8'h78, 32'h0, "no_timer_tcnt");
    bus_write(8'h7C, 32'd7);
    bus_read(8'h7C, 32'h0, "no_timer_tcmp");
    bus_write(8'h80, 32'h3);
    bus_read(8'h80, 32'h0, "no_timer_stat");
    bus_read(8'h60, 32'h00123456, "no_timer_led_intact");
    bus_idle();
  endtask
`endif

  task automatic test_reset_mid();
    bus_write(8'h60, 32'h00C3C3C3);
    bus_idle();
    sw_in = 24'h0000C3;
    repeat (8) bus_idle();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    n_checks++;
    if (led_out !== 24'h0) $display("FAIL mid_reset_led: led_out=0x%06h expected 0x000000", led_out);
    else                   n_pass++;
    bus_read(8'h60, 32'h0, "mid_reset_led_reg");
    bus_read(8'h74, 32'h0, "mid_reset_swchg");
    bus_read(8'h78, 32'h0, "mid_reset_tcnt");
`ifdef IO_TIMER_EN
    bus_read(8'h7C, 32'hFFFFFFFF, "mid_reset_tcmp");
`else
    bus_read(8'h7C, 32'h0, "mid_reset_tcmp");
`endif
    bus_read(8'h80, 32'h0, "mid_reset_stat");
    for (int k = 6; k <= 2 + DEB; k++) begin
      bus_read(8'h70, (k == 2 + DEB) ? 32'h000000C3 : 32'h0, $sformatf("mid_reset_sw_k%0d", k));
    end
    bus_read(8'h74, 32'h000000C3, "mid_reset_swchg_after");
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_led();
    test_unmapped();
    test_sw_latency();
    test_sw_glitch();
    test_sw_pattern();
`ifdef IO_TIMER_EN
    test_timer_match();
    test_timer_wrap();
`else
    test_no_timer();
`endif
    test_reset_mid();
    @(negedge clock); #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    else                   n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
